// File: rtl/a2d_spi_slave_if.sv
// a2d_spi_slave_if: SPI pins between an A2D master reader and the a2d_spi_slave responder
interface a2d_spi_slave_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_slave.sv
// a2d_spi_slave: SPI slave modelling an 8-channel 12-bit A2D; replies with the previously commanded channel
module a2d_spi_slave #(
  parameter int NUM_CH = 8,
  parameter int SAMPLE_W = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  a2d_spi_slave_if.slave             spi,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  output logic                       cmd_rdy,
  output logic [2:0]                 cmd_chnl,
  output logic                       frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] ss_q, sclk_q;
  logic [1:0] mosi_q;
  logic [15:0] tx_q, tx_d;
  logic [13:0] rx_q, rx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] chnl_q, chnl_d;
  logic rdy_q, rdy_d, err_q, err_d;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [SAMPLE_W-1:0] sample [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign sample[i] = ch_data[i*SAMPLE_W +: SAMPLE_W];
  end
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q    <= 3'b111;
      sclk_q  <= 3'b111;
      mosi_q  <= 2'b00;
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      chnl_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ss_q    <= {ss_q[1:0], spi.SS_n};
      sclk_q  <= {sclk_q[1:0], spi.SCLK};
      mosi_q  <= {mosi_q[0], spi.MOSI};
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      chnl_q  <= chnl_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end
  // rx keeps only cmd[13:0]; the channel field lands at rx[13:11] after 16 rises
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    chnl_d  = chnl_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (ss_fall) begin
        tx_d    = {{(16-SAMPLE_W){1'b0}}, sample[chnl_q]};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (ss_rise) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (sclk_rise) begin
        rx_d    = {rx_q[12:0], mosi_q[1]};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd15) ? DONE : SHIFT;
      end else if (sclk_fall && cnt_q != 5'd0) begin
        tx_d = {tx_q[14:0], 1'b0};
      end
      DONE: if (ss_rise) begin
        rdy_d   = 1'b1;
        chnl_d  = rx_q[13:11];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign spi.MISO  = (state_q != IDLE) & tx_q[15];
  assign cmd_rdy   = rdy_q;
  assign cmd_chnl  = chnl_q;
  assign frame_err = err_q;
endmodule

// File: doc/a2d_spi_slave.md
Name: a2d_spi_slave

Overview:
- Synthesizable SPI slave that models an 8-channel, 12-bit A2D converter. It is the responder to the existing SPI-master A2D readers, such as the throttle and battery readers.
- A 16-bit command frame arrives on MOSI; the channel field is cmd[13:11].
- During each frame, MISO returns {4'h0, 12-bit sample} for the channel named by the previous valid command.
- Runs entirely in the clk domain. SS_n, SCLK and MOSI are synchronised and edge-detected; they are never used as clocks.

Parameters:
- NUM_CH, 8, number of channels. Fixed at 8 because the channel field is 3 bits.
- SAMPLE_W, 12, width of each channel sample.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  reset (see Behaviour).
- SS_n  input  1  active-low slave select from the master.
- SCLK  input  1  SPI clock from the master; idles high; period ≥ 16 clk.
- MOSI  input  1  command bits, MSB first.
- ch_data  input  96  flattened samples; ch k = ch_data[12k+11:12k].
- MISO  output  1  response bits, MSB first.
- cmd_rdy  output  1  one-clk pulse: a complete, valid 16-bit command was received.
- cmd_chnl  output  3  channel field of the last valid command.
- frame_err  output  1  one-clk pulse: a frame ended with other than 16 SCLK rises.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - Reset values: MISO=0, cmd_rdy=0, frame_err=0, cmd_chnl=3'd0.
  - Also cleared: channel pointer = 0, shift registers = 0, bit counter = 0, state = IDLE.
  - Synchroniser flops preset to SS_n=1, SCLK=1.
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a 3rd flop for edge detection.
  - MOSI shares the same depth so it stays aligned with SCLK.
  - Events: sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; ss_fall and ss_rise are detected likewise.
  - Each event is detected 3 clk after the pin edge.
- State machine:
  - IDLE:
    - On ss_fall: snapshot tx_shr = {4'h0, ch_data[channel pointer]}, clear bit_cnt, go to SHIFT.
    - SCLK edges are ignored while in IDLE.
  - SHIFT:
    - On sclk_rise: rx_shr = {rx_shr[14:0], MOSI_sync}; bit_cnt++.
    - On sclk_fall with 1 ≤ bit_cnt ≤ 15: tx_shr <<= 1.
    - The fall before the first rise (bit_cnt = 0) is ignored, because the master produces one leading fall.
    - When bit_cnt reaches 16, go to DONE.
    - On ss_rise while in SHIFT: pulse frame_err, leave channel pointer and cmd_chnl unchanged, go to IDLE.
  - DONE:
    - Further SCLK edges are ignored; bit_cnt saturates at 16.
    - On ss_rise: pulse cmd_rdy; cmd_chnl and channel pointer ← rx_shr[13:11]; go to IDLE.
    - Other command bits are don't-care and are not checked.
- MISO:
  - Equals tx_shr[15] while state ≠ IDLE; 0 in IDLE.
  - Bit 15 is valid from 1 clk after ss_fall detection, well before the first rise.
- Sample coherency:
  - ch_data is sampled only at ss_fall.
  - Changes to ch_data mid-frame do not affect the frame in progress.
- Latency:
  - The response lags the command by one frame (pipelined A2D). The first frame after reset returns ch0.
  - cmd_rdy occurs 3 clk after the SS_n pin rises.
- Simultaneous ss_fall in the same clk as an ss_rise event cannot occur: these are sequential synchronised samples.
- An ss_fall while not in IDLE is impossible; if forced by glitching, it is ignored.
- Reset mid-frame: everything returns to reset values immediately, and the channel pointer returns to 0.

Test Plan:
- Reset defaults: ch0=12'h123, ch4=12'hA5C. Master sends 0x2000 (ch4) → MISO frame reads 0x0123; cmd_rdy pulses once; cmd_chnl=4.
- Back-to-back frames: frame 2 sends 0x3800 → reads 0x0A5C; cmd_chnl=7. Frame 3 sends 0x0000 with ch7=12'hFFF → reads 0x0FFF.
- Abort: SS_n raised after 8 SCLK rises during a 0x1000 command → frame_err pulses; no cmd_rdy; cmd_chnl keeps its prior value; the next frame returns the old channel.
- Snapshot: ch4 changes 12'hA5C→12'h000 at the 6th SCLK rise → the frame still reads 0x0A5C; the following ch4 frame reads 0x0000.
- Leading-fall / extra edges: inject a single SCLK fall before the first rise and 2 extra SCLK cycles after the 16th rise → the MISO word is unchanged; exactly one cmd_rdy.
- Reset mid-frame: assert rst_n low at the 10th bit → MISO=0 and state IDLE immediately. The next full frame returns ch0 data.
